// File: rtl/tcdm_error_slave.sv
// rtl/tcdm_error_slave.sv - TCDM default-port error responder with fault counter, irq and optional first-fault capture
// Optional first-fault capture registers: define ERR_SLAVE_CAPTURE_EN.
module tcdm_error_slave #(
    parameter logic [35:0] ERR_RDATA = 36'h0_BADACCE5,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic [31:0]          add_i,
    input  logic                 wen_i,
    input  logic [35:0]          wdata_i,
    input  logic [3:0]           be_i,
    output logic                 gnt_o,
    output logic                 r_valid_o,
    output logic [35:0]          r_rdata_o,
    output logic                 r_opc_o,
    input  logic                 clr_i,
    output logic                 err_irq_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic [31:0]          err_addr_o,
    output logic                 err_wen_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 handshake;
    logic                 capture_load;
    logic                 capture_clr;

    // Never back-pressures: every request is granted in its own cycle.
    assign gnt_o     = req_i;
    assign handshake = req_i & gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_o <= 1'b0;
            r_opc_o   <= 1'b0;
            r_rdata_o <= '0;
        end else begin
            r_valid_o <= handshake;
            r_opc_o   <= handshake;
            r_rdata_o <= handshake ? ERR_RDATA : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clear coinciding with a new fault restarts the record from that fault.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_load = 1'b0;
        capture_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d      = FAULT;
                    cnt_d        = CNT_ONE;
                    capture_load = 1'b1;
                end
            end
            FAULT: begin
                if (handshake && clr_i) begin
                    cnt_d        = CNT_ONE;
                    capture_load = 1'b1;
                end else if (handshake) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end else if (clr_i) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    capture_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign err_irq_o = (state_q == FAULT);
    assign err_cnt_o = cnt_q;

`ifdef ERR_SLAVE_CAPTURE_EN
    logic [31:0] addr_q;
    logic        wen_q;
    logic        unused_inputs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            wen_q  <= 1'b0;
        end else if (capture_load) begin
            addr_q <= add_i;
            wen_q  <= wen_i;
        end else if (capture_clr) begin
            addr_q <= '0;
            wen_q  <= 1'b0;
        end
    end

    assign err_addr_o    = addr_q;
    assign err_wen_o     = wen_q;
    assign unused_inputs = ^{wdata_i, be_i};
`else
    logic unused_inputs;

    assign err_addr_o    = 32'h0;
    assign err_wen_o     = 1'b0;
    assign unused_inputs = ^{wdata_i, be_i, add_i, wen_i, capture_load, capture_clr};
`endif

endmodule

// File: tb/tb_tcdm_error_slave.sv
// tb/tb_tcdm_error_slave.sv - directed scoreboard bench for tcdm_error_slave
module tb_tcdm_error_slave;

    localparam logic [35:0] ERR_RDATA = 36'h0_BADACCE5;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] add_i = '0;
    logic        wen_i = 1'b0;
    logic [35:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        clr_i = 1'b0;

    logic        gnt_o, r_valid_o, r_opc_o, err_irq_o, err_wen_o;
    logic [35:0] r_rdata_o;
    logic [15:0] err_cnt_o;
    logic [31:0] err_addr_o;

    logic        s_gnt, s_valid, s_opc, s_irq, s_wen;
    logic [35:0] s_rdata;
    logic [1:0]  s_cnt;
    logic [31:0] s_addr;

    always #5 clk_i = ~clk_i;

    tcdm_error_slave u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .clr_i(clr_i), .err_irq_o(err_irq_o),
        .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o), .err_wen_o(err_wen_o)
    );

    tcdm_error_slave #(.CNT_WIDTH(2)) u_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(s_gnt), .r_valid_o(s_valid),
        .r_rdata_o(s_rdata), .r_opc_o(s_opc), .clr_i(clr_i), .err_irq_o(s_irq),
        .err_cnt_o(s_cnt), .err_addr_o(s_addr), .err_wen_o(s_wen)
    );

    typedef struct packed {
        logic        valid;
        logic [35:0] rdata;
    } resp_t;

    resp_t       sb_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    // reference model
    logic        m_state = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [1:0]  m_cnt2 = '0;
    logic [31:0] m_addr = '0;
    logic        m_wen = 1'b0;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_addr();
`ifdef ERR_SLAVE_CAPTURE_EN
        return m_addr;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic exp_wen();
`ifdef ERR_SLAVE_CAPTURE_EN
        return m_wen;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_state = 1'b0;
        m_cnt   = '0;
        m_cnt2  = '0;
        m_addr  = '0;
        m_wen   = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".irq"},  {35'h0, err_irq_o}, {35'h0, m_state});
        chk({tag, ".cnt"},  {20'h0, err_cnt_o}, {20'h0, m_cnt});
        chk({tag, ".cnt2"}, {34'h0, s_cnt}, {34'h0, m_cnt2});
        chk({tag, ".addr"}, {4'h0, err_addr_o}, {4'h0, exp_addr()});
        chk({tag, ".wen"},  {35'h0, err_wen_o}, {35'h0, exp_wen()});
    endtask

    // One clock: drive, update model + scoreboard at the edge, compare 1ns later.
    task automatic step(input string tag, input logic req, input logic [31:0] addr,
                        input logic wen, input logic clr);
        resp_t exp_r;
        req_i   = req;
        add_i   = addr;
        wen_i   = wen;
        clr_i   = clr;
        wdata_i = {$urandom(), 4'h5};
        be_i    = 4'($urandom_range(0, 15));
        #1;
        chk({tag, ".gnt"}, {35'h0, gnt_o}, {35'h0, req});
        @(posedge clk_i);
        sb_q.push_back('{valid: req, rdata: req ? ERR_RDATA : 36'h0});
        if (req) begin
            if (!m_state || clr) begin
                m_state = 1'b1;
                m_cnt   = 16'd1;
                m_cnt2  = 2'd1;
                m_addr  = addr;
                m_wen   = wen;
            end else begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
            end
        end else if (clr && m_state) begin
            m_state = 1'b0;
            m_cnt   = '0;
            m_cnt2  = '0;
            m_addr  = '0;
            m_wen   = 1'b0;
        end
        #1;
        exp_r = sb_q.pop_front();
        chk({tag, ".rvalid"}, {35'h0, r_valid_o}, {35'h0, exp_r.valid});
        chk({tag, ".ropc"},   {35'h0, r_opc_o}, {35'h0, exp_r.valid});
        chk({tag, ".rdata"},  r_rdata_o, exp_r.rdata);
        check_state(tag);
    endtask

    initial begin
        // Reset held with a pending request
        rst_ni = 1'b0;
        req_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.gnt", {35'h0, gnt_o}, 36'h1);
        chk("rst.rvalid", {35'h0, r_valid_o}, 36'h0);
        check_state("rst");
        req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single read
        step("rd", 1'b1, 32'h1C05_0000, 1'b1, 1'b0);
        step("rd_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        step("rd_clr", 1'b0, 32'h0, 1'b0, 1'b1);

        // Burst of writes
        for (int i = 0; i < 5; i++)
            step("burst", 1'b1, 32'(i * 4), 1'b0, 1'b0);
        step("burst_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("burst.cnt5", {20'h0, err_cnt_o}, 36'd5);

        // Clear colliding with a new fault, then lone clears
        step("coll", 1'b1, 32'hDEAD_0000, 1'b1, 1'b1);
        step("lone_clr", 1'b0, 32'h0, 1'b0, 1'b1);
        step("idle_clr", 1'b0, 32'h0, 1'b0, 1'b1);

        // Saturation on the 2-bit instance
        for (int i = 0; i < 6; i++)
            step("sat", 1'b1, 32'h4000_0000 + 32'(i), i[0], 1'b0);
        chk("sat.final", {34'h0, s_cnt}, 36'd3);
        step("sat_clr", 1'b0, 32'h0, 1'b0, 1'b1);

        // Reset mid-burst
        step("mid0", 1'b1, 32'h2000_0000, 1'b1, 1'b0);
        step("mid1", 1'b1, 32'h2000_0004, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        req_i  = 1'b0;
        model_reset();
        #1;
        chk("midrst.rvalid", {35'h0, r_valid_o}, 36'h0);
        chk("midrst.rdata", r_rdata_o, 36'h0);
        check_state("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;

        step("post", 1'b1, 32'h1C05_0000, 1'b1, 1'b0);
        step("post_idle", 1'b0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
